// File: rtl/result_bus_arbiter_if.sv
// Result-bus handshake bundle: unit result ports on one side, the common bus on the other.
// master = arbiter view, slave = surrounding units/writeback view.
package result_bus_arbiter_pkg;
  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic so;
    logic ov;
    logic ca;
  } cond_exception_t;
endpackage

interface result_bus_arbiter_if #(
  parameter int UNITS       = 4,
  parameter int RS_ID_WIDTH = 5
);
  import result_bus_arbiter_pkg::*;

  logic [0:UNITS-1]                    unit_valid;
  logic [0:UNITS-1]                    unit_ready;
  logic [0:UNITS-1][0:RS_ID_WIDTH-1]   unit_rs_id;
  logic [0:UNITS-1][0:4]               unit_reg_addr;
  logic [0:UNITS-1][0:31]              unit_result;
  cond_exception_t [0:UNITS-1]         unit_cr0_xer;

  logic                                cdb_valid;
  logic                                cdb_ready;
  logic [0:RS_ID_WIDTH-1]              cdb_rs_id;
  logic [0:4]                          cdb_reg_addr;
  logic [0:31]                         cdb_result;
  cond_exception_t                     cdb_cr0_xer;

  modport master (
    input  unit_valid, unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer, cdb_ready,
    output unit_ready, cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer
  );

  modport slave (
    output unit_valid, unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer, cdb_ready,
    input  unit_ready, cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer
  );
endinterface

// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter collecting unit results into one registered common result bus slot.
module result_bus_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter int UNITS       = 4,
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  result_bus_arbiter_if.master  bus
);
  localparam int PTR_W = (UNITS > 1) ? $clog2(UNITS) : 1;

  logic [PTR_W-1:0]       r_ptr;
  logic                   r_valid;
  logic [0:RS_ID_WIDTH-1] r_rs_id;
  logic [0:4]             r_reg_addr;
  logic [0:31]            r_result;
  cond_exception_t        r_cr0_xer;

  logic                   w_found;
  logic [PTR_W-1:0]       w_gnt_idx;
  logic                   w_free;
  logic                   w_grant;
  logic [PTR_W-1:0]       w_nxt_ptr;

  // First valid unit in rotating order starting at r_ptr.
  always_comb begin
    logic [PTR_W:0] w_sum;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    for (int k = 0; k < UNITS; k++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(UNITS)) w_sum = w_sum - (PTR_W+1)'(UNITS);
      if (!w_found && bus.unit_valid[w_sum[PTR_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_sum[PTR_W-1:0];
      end
    end
  end

  // Slot frees up when empty or when its beat is consumed this cycle.
  assign w_free    = !r_valid || bus.cdb_ready;
  assign w_grant   = w_found && w_free && !rst;
  assign w_nxt_ptr = (w_gnt_idx == PTR_W'(UNITS-1)) ? '0 : w_gnt_idx + PTR_W'(1);

  always_comb begin
    bus.unit_ready = '0;
    for (int i = 0; i < UNITS; i++)
      bus.unit_ready[i] = w_grant && (w_gnt_idx == PTR_W'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_valid    <= 1'b0;
      r_rs_id    <= '0;
      r_reg_addr <= '0;
      r_result   <= '0;
      r_cr0_xer  <= '0;
    end else if (w_grant) begin
      r_ptr      <= w_nxt_ptr;
      r_valid    <= 1'b1;
      r_rs_id    <= bus.unit_rs_id[w_gnt_idx];
      r_reg_addr <= bus.unit_reg_addr[w_gnt_idx];
      r_result   <= bus.unit_result[w_gnt_idx];
      r_cr0_xer  <= bus.unit_cr0_xer[w_gnt_idx];
    end else if (bus.cdb_ready) begin
      r_valid    <= 1'b0;
    end
  end

  assign bus.cdb_valid    = r_valid;
  assign bus.cdb_rs_id    = r_rs_id;
  assign bus.cdb_reg_addr = r_reg_addr;
  assign bus.cdb_result   = r_result;
  assign bus.cdb_cr0_xer  = r_cr0_xer;
endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed bench for result_bus_arbiter: 4-unit instance plus a 3-unit instance for wrap.
module tb_result_bus_arbiter;
  import result_bus_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  result_bus_arbiter_if #(.UNITS(4), .RS_ID_WIDTH(5)) bus ();
  result_bus_arbiter_if #(.UNITS(3), .RS_ID_WIDTH(5)) bus3 ();

  result_bus_arbiter #(.UNITS(4), .RS_ID_WIDTH(5)) dut  (.clk(clk), .rst(rst), .bus(bus));
  result_bus_arbiter #(.UNITS(3), .RS_ID_WIDTH(5)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int u, input logic [4:0] rs, input logic [4:0] ra,
                          input logic [31:0] res, input logic [5:0] cx);
    bus.unit_rs_id[u]    = rs;
    bus.unit_reg_addr[u] = ra;
    bus.unit_result[u]   = res;
    bus.unit_cr0_xer[u]  = cond_exception_t'(cx);
  endtask

  task automatic set_all_fields();
    for (int u = 0; u < 4; u++)
      set_unit(u, 5'(u + 10), 5'(u + 20), 32'hA000_0000 + 32'(u), 6'(u + 1));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cdb_ready  = 1'b1;
    bus.unit_valid = 4'b1111;
    bus3.cdb_ready = 1'b0;
    bus3.unit_valid = 3'b000;
    bus3.unit_rs_id = '0; bus3.unit_reg_addr = '0; bus3.unit_result = '0; bus3.unit_cr0_xer = '0;
    set_all_fields();
    step(); step();
    checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.cdb_valid); end
    checks++; if (bus.unit_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", bus.unit_ready); end
    checks++; if (bus.cdb_rs_id !== 5'd0 || bus.cdb_reg_addr !== 5'd0) begin errors++; $display("FAIL reset_ids got=%h/%h exp=0/0", bus.cdb_rs_id, bus.cdb_reg_addr); end
    checks++; if (bus.cdb_result !== 32'd0 || bus.cdb_cr0_xer !== 6'd0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0/0", bus.cdb_result, bus.cdb_cr0_xer); end
    rst = 1'b0;
    #1;
    checks++; if (bus.unit_ready !== 4'b1000) begin errors++; $display("FAIL first_grant got=%b exp=1000", bus.unit_ready); end
    step();
    bus.unit_valid = 4'b0000;
    checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_rs_id !== 5'd10) begin errors++; $display("FAIL first_beat got=%b/%0d exp=1/10", bus.cdb_valid, bus.cdb_rs_id); end
  endtask

  task automatic test_single();
    bus.cdb_ready = 1'b1;
    step();
    checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", bus.cdb_valid); end
    set_unit(2, 5'd5, 5'd7, 32'hDEADBEEF, 6'h2A);
    bus.unit_valid = 4'b0010;
    #1;
    checks++; if (bus.unit_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got=%b exp=0010", bus.unit_ready); end
    step();
    bus.unit_valid = 4'b0000;
    checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_rs_id !== 5'd5 || bus.cdb_reg_addr !== 5'd7) begin errors++; $display("FAIL single_beat got=%b/%0d/%0d exp=1/5/7", bus.cdb_valid, bus.cdb_rs_id, bus.cdb_reg_addr); end
    checks++; if (bus.cdb_result !== 32'hDEADBEEF || bus.cdb_cr0_xer !== 6'h2A) begin errors++; $display("FAIL single_data got=%h/%h exp=deadbeef/2a", bus.cdb_result, bus.cdb_cr0_xer); end
    checks++; if (dut.r_ptr !== 2'd3) begin errors++; $display("FAIL single_ptr got=%0d exp=3", dut.r_ptr); end
    #1;
    checks++; if (bus.unit_ready !== 4'b0000) begin errors++; $display("FAIL single_idle_ready got=%b exp=0000", bus.unit_ready); end
  endtask

  task automatic test_round_robin();
    int exp_g [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
    logic [0:3] exp_rdy;
    set_all_fields();
    bus.cdb_ready  = 1'b1;
    bus.unit_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_rdy = '0;
      exp_rdy[exp_g[k]] = 1'b1;
      checks++; if (bus.unit_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, bus.unit_ready, exp_rdy); end
      step();
      checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_rs_id !== 5'(exp_g[k] + 10)) begin errors++; $display("FAIL rr_beat[%0d] got=%b/%0d exp=1/%0d", k, bus.cdb_valid, bus.cdb_rs_id, exp_g[k] + 10); end
    end
    bus.unit_valid = 4'b0000;
    step();
    checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got=%b exp=0", bus.cdb_valid); end
  endtask

  task automatic test_backpressure();
    bus.unit_valid = 4'b1000;
    step();
    bus.unit_valid = 4'b0000;
    step();
    bus.unit_valid = 4'b0101;
    #1;
    checks++; if (bus.unit_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant1 got=%b exp=0100", bus.unit_ready); end
    step();
    bus.unit_valid = 4'b0001;
    bus.cdb_ready  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.unit_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, bus.unit_ready); end
      step();
      checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_rs_id !== 5'd11 || bus.cdb_result !== 32'hA000_0001) begin errors++; $display("FAIL bp_hold[%0d] got=%b/%0d/%h exp=1/11/a0000001", k, bus.cdb_valid, bus.cdb_rs_id, bus.cdb_result); end
    end
    bus.cdb_ready = 1'b1;
    #1;
    checks++; if (bus.unit_ready !== 4'b0001) begin errors++; $display("FAIL bp_refill_ready got=%b exp=0001", bus.unit_ready); end
    step();
    bus.unit_valid = 4'b0000;
    checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_rs_id !== 5'd13) begin errors++; $display("FAIL bp_refill_beat got=%b/%0d exp=1/13", bus.cdb_valid, bus.cdb_rs_id); end
    step();
    checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%b exp=0", bus.cdb_valid); end
  endtask

  task automatic test_skip_wrap();
    bus.unit_valid = 4'b0010;
    step();
    bus.unit_valid = 4'b0000;
    step();
    checks++; if (dut.r_ptr !== 2'd3) begin errors++; $display("FAIL skip_ptr_pre got=%0d exp=3", dut.r_ptr); end
    bus.unit_valid = 4'b0100;
    #1;
    checks++; if (bus.unit_ready !== 4'b0100) begin errors++; $display("FAIL skip_ready got=%b exp=0100", bus.unit_ready); end
    step();
    bus.unit_valid = 4'b0000;
    checks++; if (dut.r_ptr !== 2'd2 || bus.cdb_rs_id !== 5'd11) begin errors++; $display("FAIL skip_grant got=%0d/%0d exp=2/11", dut.r_ptr, bus.cdb_rs_id); end
    step();
  endtask

  task automatic test_units3();
    bus3.cdb_ready     = 1'b1;
    bus3.unit_rs_id[2] = 5'd7;
    bus3.unit_rs_id[0] = 5'd4;
    bus3.unit_valid    = 3'b001;
    #1;
    checks++; if (bus3.unit_ready !== 3'b001) begin errors++; $display("FAIL u3_ready got=%b exp=001", bus3.unit_ready); end
    step();
    checks++; if (dut3.r_ptr !== 2'd0 || bus3.cdb_rs_id !== 5'd7) begin errors++; $display("FAIL u3_wrap got=%0d/%0d exp=0/7", dut3.r_ptr, bus3.cdb_rs_id); end
    bus3.unit_valid = 3'b101;
    #1;
    checks++; if (bus3.unit_ready !== 3'b100) begin errors++; $display("FAIL u3_next_ready got=%b exp=100", bus3.unit_ready); end
    step();
    bus3.unit_valid = 3'b000;
    checks++; if (bus3.cdb_rs_id !== 5'd4 || dut3.r_ptr !== 2'd1) begin errors++; $display("FAIL u3_next_beat got=%0d/%0d exp=4/1", bus3.cdb_rs_id, dut3.r_ptr); end
    step();
  endtask

  task automatic test_async_reset();
    bus.cdb_ready  = 1'b0;
    bus.unit_valid = 4'b0010;
    step();
    bus.unit_valid = 4'b0000;
    checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_rs_id !== 5'd12) begin errors++; $display("FAIL ar_held got=%b/%0d exp=1/12", bus.cdb_valid, bus.cdb_rs_id); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.cdb_valid !== 1'b0 || bus.cdb_rs_id !== 5'd0 || bus.cdb_result !== 32'd0) begin errors++; $display("FAIL ar_immediate got=%b/%0d/%h exp=0/0/0", bus.cdb_valid, bus.cdb_rs_id, bus.cdb_result); end
    #1;
    rst = 1'b0;
    step(); step();
    checks++; if (bus.cdb_valid !== 1'b0 || dut.r_ptr !== 2'd0) begin errors++; $display("FAIL ar_no_stale got=%b/%0d exp=0/0", bus.cdb_valid, dut.r_ptr); end
    bus.unit_valid = 4'b1001;
    #1;
    checks++; if (bus.unit_ready !== 4'b1000) begin errors++; $display("FAIL ar_restart got=%b exp=1000", bus.unit_ready); end
    step();
    bus.unit_valid = 4'b0000;
    checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_rs_id !== 5'd10) begin errors++; $display("FAIL ar_restart_beat got=%b/%0d exp=1/10", bus.cdb_valid, bus.cdb_rs_id); end
  endtask

  initial begin
    rst = 1'b1;
    bus.unit_valid = '0;
    bus.cdb_ready  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_skip_wrap();
    test_units3();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/result_bus_arbiter.md
# result_bus_arbiter

Collects finished results from up to UNITS execution-unit wrappers (logical, add/sub, multiply, load/store, …) over their ready-valid result ports. Picks one per cycle with fair round-robin priority and registers it onto the single common result bus. That bus feeds the register-file writeback and the reservation stations' operand-update inputs (valid, RS id, value). It is the stage directly downstream of every unit wrapper's output port.

## Interface
Parameters:
- UNITS, 4, number of execution-unit result ports (2..8).
- RS_ID_WIDTH, 5, width of reservation-station ids, identical to the unit wrappers.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- unit_valid  in  [0:UNITS-1]  result offered by unit i.
- unit_ready  out  [0:UNITS-1]  result of unit i accepted this cycle.
- unit_rs_id  in  UNITS x [0:RS_ID_WIDTH-1]  RS id of unit i's result.
- unit_reg_addr  in  UNITS x [0:4]  destination GPR of unit i.
- unit_result  in  UNITS x [0:31]  result value of unit i.
- unit_cr0_xer  in  UNITS x cond_exception_t  condition/exception bits of unit i.
- cdb_valid  out  1  result bus holds a result.
- cdb_ready  in  1  writeback consumes the bus beat.
- cdb_rs_id  out  [0:RS_ID_WIDTH-1]  RS id on the bus; also drives update_op_rs_id_in of all stations.
- cdb_reg_addr  out  [0:4]  destination GPR on the bus.
- cdb_result  out  [0:31]  value on the bus; also drives update_op_value_in.
- cdb_cr0_xer  out  cond_exception_t  condition/exception bits on the bus.

## Operation
- One output register (the bus slot), holding valid, rs_id, reg_addr, result and cr0_xer.
- Slot is free when cdb_valid=0, or when cdb_valid=1 and cdb_ready=1 in the same cycle (the pass-through refill path).
- Round-robin pointer ptr is a [0:$clog2(UNITS)-1] register, reset 0.
- Search order: ptr, ptr+1, …, wrapping modulo UNITS. The first i with unit_valid[i]=1 is the candidate.
- Grant is given only if the slot is free. unit_ready is one-hot on the granted unit, or all zero.
- unit_ready[i] may depend combinationally on unit_valid and cdb_ready. Nothing else depends combinationally on unit_ready.
- On grant to unit g, at the next edge:
  - the slot loads unit g's fields and cdb_valid goes to 1;
  - ptr becomes (g+1) mod UNITS. With non-power-of-two UNITS, the wrap is explicit.
- No grant, slot consumed (cdb_valid=1, cdb_ready=1): cdb_valid goes to 0 and ptr is unchanged.
- No grant, slot not consumed: the slot holds and ptr is unchanged.
- While cdb_valid=1 and cdb_ready=0, all slot fields are stable and unit_ready is all zero.
- A unit whose valid is low is skipped without consuming a turn.
- Stations treat cdb_valid && cdb_ready as update_op_valid. A beat is therefore broadcast exactly once.

## Timing
- Reset (asynchronous, immediate, while rst=1):
  - cdb_valid=0, ptr=0, all data fields 0;
  - unit_ready=0.
- Reset mid-operation discards any held beat. The first grant after deassertion starts search at unit 0.
- Latency: a result accepted at edge N appears on the bus after edge N, i.e. one cycle.
- Throughput: one result per cycle when cdb_ready stays 1.
- No combinational path from unit_* data inputs to cdb_* outputs.
- Simultaneous valids: exactly one grant per cycle. A unit holding valid is granted within UNITS grant cycles (starvation-free).
- Simultaneous consume and refill in one cycle: the old beat is consumed and the new beat is loaded. No bubble, no duplication.
- A unit's valid going high in the same cycle the pointer passes it is granted in that cycle if it is first in search order.

## Test plan
- Reset check: hold rst=1 with unit_valid=4'b1111 -> cdb_valid=0, unit_ready=0, data fields 0. Deassert rst -> the first grant goes to unit 0.
- Single unit: unit 2 offers rs_id=5, reg=7, result=32'hDEADBEEF with cdb_ready=1.
  - unit_ready=4'b0010 in that cycle.
  - Next cycle: cdb_valid=1, cdb_rs_id=5, cdb_reg_addr=7, cdb_result=32'hDEADBEEF.
  - ptr=3 afterwards.
- Round-robin fairness: all 4 units valid continuously, cdb_ready=1 -> grant order 0,1,2,3,0,1… with one bus beat per cycle and no bubbles.
- Backpressure: cdb_ready=0 for 3 cycles while units 1 and 3 are valid.
  - Bus holds the first beat unchanged and unit_ready=0 throughout.
  - On cdb_ready=1, the old beat is consumed and unit 3's beat loads the same cycle (ptr was 2 after granting unit 1).
- Skip and wrap: ptr=3, only unit 1 valid -> unit 1 granted, ptr becomes 2. UNITS=3 build: grant to unit 2 wraps ptr to 0.
- Async reset while cdb_valid=1 and cdb_ready=0 -> cdb_valid drops with no clock edge. After release, no stale beat reappears.
